// File: rtl/uart_tx_sched_if.sv
// Byte-producer and transmitter handshake bundle for uart_tx_sched.
// master: the producers and transmitter side. slave: the scheduler.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_done;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. It also generates the transmitter's baud enable. One byte is
// granted at a time, held until the transmitter samples it on a baud tick,
// and the next grant waits for tx_done or a watchdog timeout.
module uart_tx_sched #(
  parameter  int NUM_REQ       = 4,
  parameter  int CLK_DIV       = 868,
  parameter  int DIV_W         = 16,
  parameter  int TIMEOUT_TICKS = 16,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WD_W          = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_sched_if.slave      bus,
  output logic                baud_en,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_LOAD      = 2'b01,
    S_WAIT_DONE = 2'b10
  } state_e;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_TICKS);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               baud_en_q, baud_en_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [ID_W:0]      cand_sum;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] win_onehot;
  logic [7:0]         win_data;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    found    = 1'b0;
    win      = ptr_q;
    cand_sum = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      cand = cand_sum[ID_W-1:0];
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_data   = bus.req_data[{win, 3'b000} +: 8];
    win_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) win_onehot[j] = (win == ID_W'(j));
  end

  // Baud divider and grant/transmit state machine next-state logic.
  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    baud_en_d     = (div_cnt_q == DIV_LAST);
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    req_ready_d   = '0;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_LOAD;
          tx_valid_d  = 1'b1;
          tx_data_d   = win_data;
          grant_id_d  = win;
          ptr_d       = win;
          req_ready_d = win_onehot;
        end
      end
      S_LOAD: begin
        // The transmitter samples the byte on the baud tick.
        if (baud_en_q) begin
          state_d    = S_WAIT_DONE;
          tx_valid_d = 1'b0;
          wd_cnt_d   = '0;
        end
      end
      S_WAIT_DONE: begin
        // Frame completion takes priority over a coincident timeout.
        if (bus.tx_done) begin
          state_d = S_IDLE;
        end else if (baud_en_q) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
          if (wd_cnt_d == WD_LIMIT) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; everything clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      baud_en_q     <= 1'b0;
      wd_cnt_q      <= '0;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      req_ready_q   <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      baud_en_q     <= baud_en_d;
      wd_cnt_q      <= wd_cnt_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      req_ready_q   <= req_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign baud_en       = baud_en_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: arbitration vectors from a table,
// plus directed sequences for baud timing, back-to-back service, watchdog
// timeout, tx_done/timeout collision and reset in mid-frame.
module tb_uart_tx_sched;
  localparam int NUM_REQ       = 4;
  localparam int CLK_DIV       = 4;
  localparam int DIV_W         = 16;
  localparam int TIMEOUT_TICKS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_en;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_sched #(
    .NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV), .DIV_W(DIV_W), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .baud_en(baud_en),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] data;
    logic [1:0]  eid;
    logic [3:0]  erdy;
    logic [7:0]  edata;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (check first, then advance) for a DUT event; an expired budget is a failure.
  task automatic wait_for(input int which, input string name, input int budget);
    bit hit;
    for (int i = 0; i < budget; i++) begin
      case (which)
        0:       hit = baud_en;
        1:       hit = |bus.req_ready;
        default: hit = timeout_err;
      endcase
      if (hit) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL %s: event not seen within %0d cycles", name, budget);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " baud_en"}, baud_en, 0);
    check({tag, " tx_valid"}, bus.tx_valid, 0);
    check({tag, " tx_data"}, bus.tx_data, 8'h00);
    check({tag, " req_ready"}, bus.req_ready, 0);
    check({tag, " grant_id"}, grant_id, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called in the first cycle after a grant edge. Checks the grant, then
  // follows tx_valid through the sampling baud tick. Returns in the first
  // cycle with tx_valid low.
  task automatic grant_check(input string tag, input logic [1:0] eid, input logic [3:0] erdy,
                             input logic [7:0] edata, input bit withdraw);
    bit tick_now;
    check({tag, " req_ready"}, bus.req_ready, erdy);
    check({tag, " grant_id"}, grant_id, eid);
    check({tag, " tx_data"}, bus.tx_data, edata);
    check({tag, " tx_valid"}, bus.tx_valid, 1);
    check({tag, " busy"}, busy, 1);
    if (withdraw) bus.req_valid = bus.req_valid & ~erdy;
    tick_now = baud_en;
    @(negedge clk);
    check({tag, " req_ready pulse"}, bus.req_ready, 0);
    if (!tick_now) begin
      check({tag, " tx_valid hold"}, bus.tx_valid, 1);
      wait_for(0, {tag, " baud"}, 3 * CLK_DIV);
      check({tag, " tx_valid at tick"}, bus.tx_valid, 1);
      @(negedge clk);
    end
    check({tag, " tx_valid drop"}, bus.tx_valid, 0);
    check({tag, " busy in wait"}, busy, 1);
  endtask

  initial begin
    int ticks;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;

    vecs[0] = '{4'b0001, 32'h0000_00A5, 2'd0, 4'b0001, 8'hA5};
    vecs[1] = '{4'b0001, 32'h0000_003C, 2'd0, 4'b0001, 8'h3C};
    vecs[2] = '{4'b1010, 32'h3300_1100, 2'd1, 4'b0010, 8'h11};
    vecs[3] = '{4'b1010, 32'h3300_1100, 2'd3, 4'b1000, 8'h33};
    vecs[4] = '{4'b0110, 32'h0044_2200, 2'd1, 4'b0010, 8'h22};
    vecs[5] = '{4'b1001, 32'h6600_0055, 2'd3, 4'b1000, 8'h66};
    vecs[6] = '{4'b1111, 32'h8382_8180, 2'd0, 4'b0001, 8'h80};
    vecs[7] = '{4'b0100, 32'h00C3_0000, 2'd2, 4'b0100, 8'hC3};
    vecs[8] = '{4'b1110, 32'hD3D2_D1D0, 2'd3, 4'b1000, 8'hD3};
    vecs[9] = '{4'b0111, 32'h00B2_B1B0, 2'd0, 4'b0001, 8'hB0};

    // Reset values while rst_n is held low.
    #12;
    check_reset("por");

    // Baud divider: first tick 4 edges after release, then every 4th.
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("baud cyc%0d", n), baud_en, (n % CLK_DIV == 0) ? 1 : 0);
    end

    // Table-driven arbitration, one full frame per vector.
    for (int v = 0; v < 10; v++) begin
      bus.req_valid = vecs[v].rv;
      bus.req_data  = vecs[v].data;
      @(negedge clk);
      grant_check($sformatf("vec%0d", v), vecs[v].eid, vecs[v].erdy, vecs[v].edata, 1'b1);
      bus.req_valid = '0;
      wait_for(0, $sformatf("vec%0d wait tick", v), 3 * CLK_DIV);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check($sformatf("vec%0d busy after done", v), busy, 0);
      check($sformatf("vec%0d tx_data held", v), bus.tx_data, vecs[v].edata);
      @(negedge clk);
      check($sformatf("vec%0d idle ready", v), bus.req_ready, 0);
      check($sformatf("vec%0d idle busy", v), busy, 0);
    end

    // Back-to-back: all requesters held, tx_done 12 ticks after each grant.
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h9392_9190;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      wait_for(1, $sformatf("rr%0d grant", k), 10);
      grant_check($sformatf("rr%0d", k), 2'(k % 4), 4'(1 << (k % 4)), 8'h90 + 8'(k % 4), 1'b0);
      ticks = 1;
      for (int i = 0; i < 200 && ticks < 12; i++) begin
        @(negedge clk);
        if (baud_en) ticks++;
      end
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end

    // Watchdog: no tx_done, abort on the 16th tick, next requester granted.
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_data  = 32'h0000_2110;
    @(negedge clk);
    grant_check("to g0", 2'd0, 4'b0001, 8'h10, 1'b1);
    ticks = 0;
    for (int i = 0; i < 200 && !timeout_err; i++) begin
      if (baud_en) ticks++;
      @(negedge clk);
    end
    check("to err pulse", timeout_err, 1);
    check("to tick count", ticks, TIMEOUT_TICKS);
    check("to busy idle", busy, 0);
    @(negedge clk);
    check("to err one cycle", timeout_err, 0);
    grant_check("to g1", 2'd1, 4'b0010, 8'h21, 1'b1);

    // tx_done on the same edge as the 16th tick: no error.
    ticks = 0;
    for (int i = 0; i < 200 && ticks < TIMEOUT_TICKS; i++) begin
      if (baud_en) ticks++;
      if (ticks < TIMEOUT_TICKS) @(negedge clk);
    end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("coll no err", timeout_err, 0);
    check("coll busy idle", busy, 0);
    @(negedge clk);
    check("coll no late err", timeout_err, 0);

    // Reset during LOAD: outputs cleared, no re-issue, requester 0 first.
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h0077_0000;
    @(negedge clk);
    check("midld ready", bus.req_ready, 4'b0100);
    check("midld tx_valid", bus.tx_valid, 1);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    check_reset("midld rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midld no reissue", bus.req_ready, 0);
    check("midld idle", busy, 0);
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'hE3E2_E1E0;
    @(negedge clk);
    check("midld first ready", bus.req_ready, 4'b0001);
    check("midld first id", grant_id, 0);
    check("midld first data", bus.tx_data, 8'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end
endmodule
